// File: rtl/dram_req_pkg.sv
// Shared types for the DRAM read-request path: address/period words, FIFO word width
// and the read scheduler state encoding.
package dram_req_pkg;

    localparam int ADDR_W      = 24;
    localparam int PERIOD_W    = 14;
    localparam int FIFO_WORD_W = ADDR_W + PERIOD_W;

    typedef logic [ADDR_W-1:0]   addr_t;
    typedef logic [PERIOD_W-1:0] period_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SEND
    } sched_state_t;

endpackage

// File: rtl/dram_read_scheduler_lowest_set_pick.sv
// Combinational lowest-set-bit picker: returns the index of the lowest set bit and
// whether any set bit lies above it (used to flag the last word of a frame).
module lowest_set_pick #(
    parameter  int WIDTH = 3,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] i_mask,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_higher
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        o_idx    = '0;
        o_any    = 1'b0;
        o_higher = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_mask[i]) begin
                if (o_any) begin
                    o_higher = 1'b1;
                end else begin
                    o_idx = IDX_W'(i);
                    o_any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dram_read_scheduler.sv
// Per-frame DRAM read-request sequencer: snapshots pending instruments at frame_start and
// issues one {addr, period} AXI-Stream word per instrument in index order.
module dram_read_scheduler
    import dram_req_pkg::*;
#(
    parameter int INSTRUMENT_COUNT = 3,
    parameter int ADDR_WIDTH       = 24,
    parameter int PERIOD_WIDTH     = 14
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         frame_start,
    input  logic [PERIOD_WIDTH-1:0]                      sample_period,
    input  logic [INSTRUMENT_COUNT-1:0]                  req_valid,
    input  logic [INSTRUMENT_COUNT-1:0][ADDR_WIDTH-1:0]  req_addr,
    output logic [INSTRUMENT_COUNT-1:0]                  req_ack,
    input  logic                                         fifo_prog_full,
    output logic                                         m_axis_tvalid,
    input  logic                                         m_axis_tready,
    output logic [ADDR_WIDTH+PERIOD_WIDTH-1:0]           m_axis_tdata,
    output logic                                         m_axis_tlast,
    output logic                                         busy,
    output logic [7:0]                                   overrun_count
);

    localparam int IDX_W = (INSTRUMENT_COUNT > 1) ? $clog2(INSTRUMENT_COUNT) : 1;

    sched_state_t                            r_state;
    sched_state_t                            w_next_state;
    logic [INSTRUMENT_COUNT-1:0]             r_pend_mask;
    logic [INSTRUMENT_COUNT-1:0]             r_req_ack;
    logic [PERIOD_WIDTH-1:0]                 r_period;
    logic [ADDR_WIDTH+PERIOD_WIDTH-1:0]      r_tdata;
    logic                                    r_tlast;
    logic [IDX_W-1:0]                        r_k;
    logic [7:0]                              r_overrun;

    logic [IDX_W-1:0]                        w_pick_idx;
    logic                                    w_pick_any;
    logic                                    w_pick_higher;
    logic [INSTRUMENT_COUNT-1:0]             w_sent_onehot;
    logic [INSTRUMENT_COUNT-1:0]             w_mask_after;

    lowest_set_pick #(
        .WIDTH (INSTRUMENT_COUNT)
    ) u_pick (
        .i_mask   (r_pend_mask),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any),
        .o_higher (w_pick_higher)
    );

    assign w_sent_onehot = INSTRUMENT_COUNT'(1) << r_k;
    assign w_mask_after  = r_pend_mask & ~w_sent_onehot;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (frame_start && (|req_valid))       w_next_state = SCAN;
            SCAN: if (!fifo_prog_full && w_pick_any)     w_next_state = SEND;
            SEND: if (m_axis_tready)                     w_next_state = (|w_mask_after) ? SCAN : IDLE;
            default:                                     w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_mask <= '0;
            r_req_ack   <= '0;
            r_period    <= '0;
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_k         <= '0;
            r_overrun   <= '0;
        end else begin
            r_req_ack <= '0;
            // A frame is only accepted in IDLE, so the final-handshake cycle still counts as busy.
            if (frame_start && (r_state != IDLE) && (r_overrun != 8'hFF))
                r_overrun <= r_overrun + 8'd1;
            case (r_state)
                IDLE: begin
                    if (frame_start) begin
                        r_pend_mask <= req_valid;
                        r_period    <= sample_period;
                    end
                end
                SCAN: begin
                    if (!fifo_prog_full && w_pick_any) begin
                        r_tdata <= {req_addr[w_pick_idx], r_period};
                        r_tlast <= !w_pick_higher;
                        r_k     <= w_pick_idx;
                    end
                end
                SEND: begin
                    if (m_axis_tready) begin
                        r_pend_mask <= w_mask_after;
                        r_req_ack   <= w_sent_onehot;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = (r_state == SEND);
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign req_ack       = r_req_ack;
    assign busy          = (r_state != IDLE);
    assign overrun_count = r_overrun;

endmodule

// File: tb/tb_dram_read_scheduler.sv
// Directed bench for dram_read_scheduler: frame ordering, backpressure, overruns and reset abort.
module tb_dram_read_scheduler;

    localparam int N  = 3;
    localparam int AW = 24;
    localparam int PW = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic [PW-1:0]     sample_period;
    logic [N-1:0]      req_valid;
    logic [N-1:0][AW-1:0] req_addr;
    logic [N-1:0]      req_ack;
    logic              fifo_prog_full;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [AW+PW-1:0]  m_axis_tdata;
    logic              m_axis_tlast;
    logic              busy;
    logic [7:0]        overrun_count;

    int n_vec  = 0;
    int n_miss = 0;

    localparam logic [AW-1:0] A0  = 24'h000100;
    localparam logic [AW-1:0] A1  = 24'h020000;
    localparam logic [AW-1:0] A2  = 24'h040000;
    localparam logic [PW-1:0] PER = 14'h0A2C;

    dram_read_scheduler #(
        .INSTRUMENT_COUNT (N),
        .ADDR_WIDTH       (AW),
        .PERIOD_WIDTH     (PW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .frame_start    (frame_start),
        .sample_period  (sample_period),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ack        (req_ack),
        .fifo_prog_full (fifo_prog_full),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tlast   (m_axis_tlast),
        .busy           (busy),
        .overrun_count  (overrun_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [AW-1:0] addr, input logic last);
        check({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'd1);
        check({tag, ".tdata"},  64'(m_axis_tdata),  64'({addr, PER}));
        check({tag, ".tlast"},  64'(m_axis_tlast),  64'(last));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        frame_start    = 1'b0;
        sample_period  = PER;
        req_valid      = '0;
        req_addr       = {A2, A1, A0};
        fifo_prog_full = 1'b0;
        m_axis_tready  = 1'b1;
        step();
        step();
        check("rst.tvalid",  64'(m_axis_tvalid), 64'd0);
        check("rst.busy",    64'(busy),          64'd0);
        check("rst.ack",     64'(req_ack),       64'd0);
        check("rst.overrun", 64'(overrun_count), 64'd0);
        check("rst.tdata",   64'(m_axis_tdata),  64'd0);
        rst = 1'b0;
        step();

        // Full frame, tready high: words at t+2/4/6, acks at t+3/5/7.
        req_valid   = 3'b111;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("f1.t1.busy",   64'(busy),          64'd1);
        check("f1.t1.tvalid", 64'(m_axis_tvalid), 64'd0);
        step();
        check_word("f1.w0", A0, 1'b0);
        check("f1.t2.ack", 64'(req_ack), 64'd0);
        step();
        check("f1.t3.ack",    64'(req_ack),       64'b001);
        check("f1.t3.tvalid", 64'(m_axis_tvalid), 64'd0);
        step();
        check_word("f1.w1", A1, 1'b0);
        step();
        check("f1.t5.ack", 64'(req_ack), 64'b010);
        step();
        check_word("f1.w2", A2, 1'b1);
        step();
        check("f1.t7.ack",    64'(req_ack),       64'b100);
        check("f1.t7.busy",   64'(busy),          64'd0);
        check("f1.t7.tvalid", 64'(m_axis_tvalid), 64'd0);

        // Single requester, then empty frame.
        req_valid   = 3'b010;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        check_word("f2.w", A1, 1'b1);
        step();
        check("f2.ack",  64'(req_ack), 64'b010);
        check("f2.busy", 64'(busy),    64'd0);
        req_valid   = 3'b000;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("f3.busy", 64'(busy), 64'd0);
        step();
        check("f3.tvalid", 64'(m_axis_tvalid), 64'd0);
        check("f3.busy2",  64'(busy),          64'd0);

        // tready low for 5 cycles during word 0.
        req_valid     = 3'b011;
        m_axis_tready = 1'b0;
        frame_start   = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            check_word($sformatf("f4.hold%0d", i), A0, 1'b0);
            check($sformatf("f4.hold%0d.ack", i), 64'(req_ack), 64'd0);
            step();
        end
        m_axis_tready = 1'b1;
        check_word("f4.rel", A0, 1'b0);
        step();
        check("f4.ack0", 64'(req_ack), 64'b001);
        step();
        check_word("f4.w1", A1, 1'b1);
        step();
        check("f4.ack1", 64'(req_ack), 64'b010);
        check("f4.busy", 64'(busy),    64'd0);

        // prog_full high across frame_start, released after 10 cycles; FSM waits in SCAN.
        req_valid      = 3'b111;
        fifo_prog_full = 1'b1;
        frame_start    = 1'b1;
        step();
        frame_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("f5.pf%0d.tvalid", i), 64'(m_axis_tvalid), 64'd0);
            step();
        end
        check("f5.pf.busy", 64'(busy), 64'd1);
        fifo_prog_full = 1'b0;
        step();
        check_word("f5.w0", A0, 1'b0);
        // prog_full rising during SEND does not stop the word already presented.
        fifo_prog_full = 1'b1;
        step();
        check("f5.ack0", 64'(req_ack), 64'b001);
        step();
        check("f5.hold.tvalid", 64'(m_axis_tvalid), 64'd0);
        fifo_prog_full = 1'b0;
        step();
        check_word("f5.w1", A1, 1'b0);
        step();
        step();
        check_word("f5.w2", A2, 1'b1);
        step();
        check("f5.ack2", 64'(req_ack), 64'b100);

        // 300 frame_start pulses while busy: frame untouched, overrun saturates.
        m_axis_tready = 1'b0;
        frame_start   = 1'b1;
        step();
        check("f6.ovr.start", 64'(overrun_count), 64'd0);
        for (int i = 0; i < 300; i++) begin
            if (i == 10) check("f6.ovr10", 64'(overrun_count), 64'd10);
            step();
        end
        frame_start = 1'b0;
        check("f6.ovr.sat", 64'(overrun_count), 64'd255);
        check_word("f6.w0", A0, 1'b0);
        m_axis_tready = 1'b1;
        step();
        check("f6.ack0", 64'(req_ack), 64'b001);
        step();
        check_word("f6.w1", A1, 1'b0);
        step();
        step();
        check_word("f6.w2", A2, 1'b1);
        step();
        check("f6.done.busy", 64'(busy), 64'd0);

        // Reset during SEND of word 1: abort with no ack, overrun cleared.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        step();
        step();
        check_word("f7.w1", A1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("f7.rst.tvalid",  64'(m_axis_tvalid), 64'd0);
        check("f7.rst.busy",    64'(busy),          64'd0);
        check("f7.rst.ack",     64'(req_ack),       64'd0);
        check("f7.rst.overrun", 64'(overrun_count), 64'd0);
        step();
        check("f7.post.ack", 64'(req_ack), 64'd0);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        check_word("f7.restart", A0, 1'b0);
        step();
        step();
        step();
        step();
        step();
        check("f7.end.busy", 64'(busy), 64'd0);

        // frame_start coinciding with the final handshake is an overrun and starts nothing.
        req_valid   = 3'b001;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        check_word("f8.w", A0, 1'b1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("f8.ovr",  64'(overrun_count), 64'd1);
        check("f8.busy", 64'(busy),          64'd0);
        step();
        check("f8.tvalid", 64'(m_axis_tvalid), 64'd0);
        check("f8.busy2",  64'(busy),          64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
